// File: rtl/rm_lane_allocator.sv
// rtl/rm_lane_allocator.sv - runtime-monitor lane allocator with busy bitmap and registered command.
// Optional statistics counters are built only when RM_ALLOC_STATS_EN is defined.
package ariane_pkg;
  localparam int unsigned MON_IDX_W = 3;

  typedef enum logic [0:0] {
    MON_LOAD  = 1'b0,
    MON_STORE = 1'b1
  } monitored_itype;

  typedef struct packed {
    logic                 monitor_ins;
    logic [MON_IDX_W-1:0] idx;
    monitored_itype       itype;
    logic [MON_IDX_W-1:0] lane0;
    logic [MON_IDX_W-1:0] lane1;
    logic                 two_lane;
    logic [MON_IDX_W-1:0] p_idx;
  } runtime_monitor_ctrl;
endpackage

module rm_lane_allocator
  import ariane_pkg::*;
#(
  parameter int unsigned NUM_LANES         = 5,
  parameter int unsigned NUM_MONITORED_INS = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [$clog2(NUM_LANES)-1:0] req_idx_i,
  input  monitored_itype               req_itype_i,
  input  logic                         req_two_lane_i,
  input  logic [NUM_LANES-1:0]         lane_reset_i,
  output runtime_monitor_ctrl          monitor_o,
  output logic [31:0]                  alloc_cnt_o,
  output logic [31:0]                  stall_cnt_o
);

  localparam int unsigned IDX_W = $clog2(NUM_LANES);
  localparam int unsigned CNT_W = $clog2(NUM_LANES + 1);

  if (NUM_MONITORED_INS > (1 << $bits(monitored_itype))) begin : g_itype_check
    $error("NUM_MONITORED_INS exceeds the monitored_itype encoding");
  end

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_LANES-1:0] busy_q, busy_d, alloc_mask;
  logic [CNT_W-1:0]     free_cnt_q, free_cnt_d, busy_cnt, need;
  logic [IDX_W-1:0]     tail_idx_q, tail_idx_d;
  logic                 tail_valid_q, tail_valid_d;
  logic [IDX_W-1:0]     lane0, lane1_raw, lane1;
  logic                 found0, found1;
  logic                 two_eff, accept;
  runtime_monitor_ctrl  monitor_q, monitor_d;

  // Without a parent entry a two-lane request degrades to a single lane.
  assign two_eff     = req_two_lane_i && tail_valid_q;
  assign need        = two_eff ? CNT_W'(2) : CNT_W'(1);
  assign req_ready_o = (state_q == RUN) && (free_cnt_q >= need);
  assign accept      = req_valid_i && req_ready_o && !flush_i;
  assign lane1       = two_eff ? lane1_raw : '0;
  assign monitor_o   = monitor_q;

  // Lanes released this cycle are still busy in busy_q, so they are never picked here.
  always_comb begin
    lane0     = '0;
    lane1_raw = '0;
    found0    = 1'b0;
    found1    = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!busy_q[k]) begin
        if (!found0) begin
          found0 = 1'b1;
          lane0  = IDX_W'(k);
        end else if (!found1) begin
          found1    = 1'b1;
          lane1_raw = IDX_W'(k);
        end
      end
    end
  end

  always_comb begin
    alloc_mask = '0;
    if (accept) begin
      alloc_mask[lane0] = 1'b1;
      if (two_eff) alloc_mask[lane1] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = (busy_q & ~lane_reset_i) | alloc_mask;
    tail_idx_d   = tail_idx_q;
    tail_valid_d = tail_valid_q;
    monitor_d    = '0;
    case (state_q)
      RUN: begin
        if (flush_i) begin
          state_d      = FLUSH;
          busy_d       = '0;
          tail_valid_d = 1'b0;
        end else if (accept) begin
          tail_idx_d            = req_idx_i;
          tail_valid_d          = 1'b1;
          monitor_d.monitor_ins = 1'b1;
          monitor_d.idx         = MON_IDX_W'(req_idx_i);
          monitor_d.itype       = req_itype_i;
          monitor_d.lane0       = MON_IDX_W'(lane0);
          monitor_d.lane1       = MON_IDX_W'(lane1);
          monitor_d.two_lane    = two_eff;
          monitor_d.p_idx       = MON_IDX_W'(tail_idx_q);
        end else if ((|busy_q) && (busy_d == '0)) begin
          tail_valid_d = 1'b0;
        end
      end
      FLUSH: begin
        if (flush_i) begin
          busy_d       = '0;
          tail_valid_d = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    busy_cnt = '0;
    for (int k = 0; k < NUM_LANES; k++) busy_cnt = busy_cnt + CNT_W'(busy_d[k]);
    free_cnt_d = CNT_W'(NUM_LANES) - busy_cnt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      busy_q       <= '0;
      free_cnt_q   <= CNT_W'(NUM_LANES);
      tail_idx_q   <= '0;
      tail_valid_q <= 1'b0;
      monitor_q    <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      free_cnt_q   <= free_cnt_d;
      tail_idx_q   <= tail_idx_d;
      tail_valid_q <= tail_valid_d;
      monitor_q    <= monitor_d;
    end
  end

`ifdef RM_ALLOC_STATS_EN
  logic [31:0] alloc_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept) alloc_cnt_q <= alloc_cnt_q + 32'd1;
      if ((state_q == RUN) && req_valid_i && !req_ready_o) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign alloc_cnt_o = alloc_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign alloc_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rm_lane_allocator.sv
// tb/tb_rm_lane_allocator.sv - directed and randomized checks of rm_lane_allocator against a lane-list model.
module tb_rm_lane_allocator;
  import ariane_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_i, flush_i, req_valid_i, req_ready_o, req_two_lane_i;
  logic [2:0]          req_idx_i;
  monitored_itype      req_itype_i;
  logic [4:0]          lane_reset_i;
  runtime_monitor_ctrl monitor_o;
  logic [31:0]         alloc_cnt_o, stall_cnt_o;

  int tests = 0;
  int fails = 0;

  bit                  mbusy [5];
  int                  mtail_idx;
  bit                  mtail_v;
  bit                  mflush;
  int unsigned         malloc_n, mstall_n;
  runtime_monitor_ctrl mmon;
  logic                last_ready;

  always #5 clk_i = ~clk_i;

  rm_lane_allocator dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_idx_i      (req_idx_i),
    .req_itype_i    (req_itype_i),
    .req_two_lane_i (req_two_lane_i),
    .lane_reset_i   (lane_reset_i),
    .monitor_o      (monitor_o),
    .alloc_cnt_o    (alloc_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_free();
    int f = 0;
    for (int k = 0; k < 5; k++) if (!mbusy[k]) f++;
    return f;
  endfunction

  function automatic int m_need();
    return (req_two_lane_i && mtail_v) ? 2 : 1;
  endfunction

  function automatic bit m_ready();
    return !mflush && (m_free() >= m_need());
  endfunction

  function automatic logic [4:0] m_busy_vec();
    logic [4:0] v;
    for (int k = 0; k < 5; k++) v[k] = mbusy[k];
    return v;
  endfunction

  function automatic logic [31:0] exp_alloc();
`ifdef RM_ALLOC_STATS_EN
    return malloc_n;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_stall();
`ifdef RM_ALLOC_STATS_EN
    return mstall_n;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 5; k++) mbusy[k] = 1'b0;
    mtail_idx = 0;
    mtail_v   = 1'b0;
    mflush    = 1'b0;
    malloc_n  = 0;
    mstall_n  = 0;
    mmon      = '0;
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    int  need = m_need();
    bit  rdy  = m_ready();
    bit  acc  = req_valid_i && rdy && !flush_i;
    bit  was_busy = (m_busy_vec() != 5'b0);
    int  l0 = -1;
    int  l1 = -1;
    if (!mflush && req_valid_i && !rdy) mstall_n++;
    mmon = '0;
    if (acc) begin
      for (int k = 0; k < 5; k++) begin
        if (!mbusy[k] && l0 < 0) l0 = k;
        else if (!mbusy[k] && l1 < 0 && need == 2) l1 = k;
      end
      mmon.monitor_ins = 1'b1;
      mmon.idx         = req_idx_i;
      mmon.itype       = req_itype_i;
      mmon.lane0       = 3'(l0);
      mmon.lane1       = (need == 2) ? 3'(l1) : 3'd0;
      mmon.two_lane    = (need == 2);
      mmon.p_idx       = 3'(mtail_idx);
      malloc_n++;
    end
    for (int k = 0; k < 5; k++) begin
      if (acc && (k == l0 || k == l1)) mbusy[k] = 1'b1;
      else if (lane_reset_i[k]) mbusy[k] = 1'b0;
    end
    if (flush_i) begin
      for (int k = 0; k < 5; k++) mbusy[k] = 1'b0;
      mtail_v = 1'b0;
    end else if (acc) begin
      mtail_idx = req_idx_i;
      mtail_v   = 1'b1;
    end else if (was_busy && m_busy_vec() == 5'b0) begin
      mtail_v = 1'b0;
    end
    mflush = flush_i;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_mon"}, 64'(monitor_o), 64'(mmon));
    chk({tag, "_busy"}, 64'(dut.busy_q), 64'(m_busy_vec()));
    chk({tag, "_alloc"}, 64'(alloc_cnt_o), 64'(exp_alloc()));
    chk({tag, "_stall"}, 64'(stall_cnt_o), 64'(exp_stall()));
  endtask

  // Called at posedge+1; applies inputs, checks ready, clocks, checks registered state.
  task automatic drive(input string tag, input logic v, input logic [2:0] idx, input logic two,
                       input logic [4:0] lr, input logic fl);
    req_valid_i    = v;
    req_idx_i      = idx;
    req_two_lane_i = two;
    req_itype_i    = monitored_itype'($urandom_range(0, 1));
    lane_reset_i   = lr;
    flush_i        = fl;
    #1;
    last_ready = req_ready_o;
    chk({tag, "_ready"}, 64'(req_ready_o), 64'(m_ready()));
    @(posedge clk_i);
    model_step();
    #1;
    check_regs(tag);
  endtask

  task automatic do_reset();
    rst_i          = 1'b1;
    flush_i        = 1'b1;
    req_valid_i    = 1'b1;
    req_idx_i      = 3'd0;
    req_two_lane_i = 1'b0;
    req_itype_i    = MON_LOAD;
    lane_reset_i   = 5'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i       = 1'b0;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    model_reset();
    check_regs("reset");
  endtask

  initial begin
    logic [4:0] lr;
    do_reset();

    drive("r033", 1, 3'd2, 0, 5'b0, 0);
    chk("r033_ins", 64'(monitor_o.monitor_ins), 64'd1);
    chk("r033_idx", 64'(monitor_o.idx), 64'd2);
    chk("r033_lane0", 64'(monitor_o.lane0), 64'd0);
    chk("r033_two", 64'(monitor_o.two_lane), 64'd0);
    chk("r033_busyc", 64'(dut.busy_q), 64'b00001);

    drive("r034", 1, 3'd3, 1, 5'b0, 0);
    chk("r034_lane0", 64'(monitor_o.lane0), 64'd1);
    chk("r034_lane1", 64'(monitor_o.lane1), 64'd2);
    chk("r034_pidx", 64'(monitor_o.p_idx), 64'd2);
    chk("r034_two", 64'(monitor_o.two_lane), 64'd1);
    chk("r034_busyc", 64'(dut.busy_q), 64'b00111);
    drive("r034_idle", 0, 3'd0, 0, 5'b0, 0);
    chk("r034_pulse", 64'(monitor_o), 64'd0);

    do_reset();
    for (int i = 0; i < 5; i++) drive("r035_fill", 1, 3'(i), 0, 5'b0, 0);
    drive("r035_full", 1, 3'd0, 0, 5'b00100, 0);
    chk("r035_ready0", 64'(last_ready), 64'd0);
    drive("r035_grant", 1, 3'd1, 0, 5'b0, 0);
    chk("r035_ready1", 64'(last_ready), 64'd1);
    chk("r035_lane0", 64'(monitor_o.lane0), 64'd2);

    drive("r036_rel", 0, 3'd0, 0, 5'b10000, 0);
    drive("r036_wait", 1, 3'd4, 1, 5'b0, 0);
    chk("r036_ready_a", 64'(last_ready), 64'd0);
    drive("r036_wait2", 1, 3'd4, 1, 5'b00001, 0);
    chk("r036_ready_b", 64'(last_ready), 64'd0);
    drive("r036_grant", 1, 3'd4, 1, 5'b0, 0);
    chk("r036_ready_c", 64'(last_ready), 64'd1);
    chk("r036_lane0", 64'(monitor_o.lane0), 64'd0);
    chk("r036_lane1", 64'(monitor_o.lane1), 64'd4);

    do_reset();
    for (int i = 0; i < 4; i++) drive("r037_fill", 1, 3'(i), 0, 5'b0, 0);
    drive("r037_rel", 0, 3'd0, 0, 5'b00100, 0);
    chk("r037_busy01011", 64'(dut.busy_q), 64'b01011);
    drive("r037_flush", 1, 3'd4, 0, 5'b0, 1);
    chk("r037_nopulse", 64'(monitor_o), 64'd0);
    chk("r037_cleared", 64'(dut.busy_q), 64'd0);
    drive("r037_hold", 1, 3'd4, 0, 5'b0, 0);
    chk("r037_ready0", 64'(last_ready), 64'd0);
    drive("r037_back", 1, 3'd4, 0, 5'b0, 0);
    chk("r037_ready1", 64'(last_ready), 64'd1);

    do_reset();
    drive("r038_g1", 1, 3'd0, 0, 5'b0, 0);
    drive("r038_g2", 1, 3'd1, 1, 5'b0, 0);
    drive("r038_g3", 1, 3'd2, 0, 5'b0, 0);
    for (int i = 0; i < 4; i++) drive("r038_stall", 1, 3'd3, 1, 5'b0, 0);
    drive("r038_idle", 0, 3'd0, 0, 5'b0, 0);
`ifdef RM_ALLOC_STATS_EN
    chk("r038_alloc", 64'(alloc_cnt_o), 64'd3);
    chk("r038_stall", 64'(stall_cnt_o), 64'd4);
`else
    chk("r038_alloc", 64'(alloc_cnt_o), 64'd0);
    chk("r038_stall", 64'(stall_cnt_o), 64'd0);
`endif

    for (int i = 0; i < 600; i++) begin
      lr = 5'($urandom) & m_busy_vec();
      if ($urandom_range(0, 19) == 0) lr = 5'($urandom);
      drive("rand", ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 4)), 1'($urandom),
            lr, ($urandom_range(0, 29) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rm_lane_allocator.md
RM_LANE_ALLOCATOR -- requirements
Module: rm_lane_allocator

Interface
REQ-001 SHALL have parameter NUM_LANES, default 5, number of monitor lanes and monitored-entry indices.
REQ-002 SHALL have parameter NUM_MONITORED_INS, default 2, number of monitored instruction types.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk_i  input  1  rising-edge clock.
REQ-005 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port flush_i  input  1  pipeline flush; abandons all allocations.
REQ-007 SHALL have port req_valid_i  input  1  monitored instruction offered.
REQ-008 SHALL have port req_ready_o  output  1  request accepted this cycle when high with req_valid_i.
REQ-009 SHALL have port req_idx_i  input  $clog2(NUM_LANES)  monitored-entry index.
REQ-010 SHALL have port req_itype_i  input  ariane_pkg::monitored_itype  instruction type.
REQ-011 SHALL have port req_two_lane_i  input  1  request needs two lanes.
REQ-012 SHALL have port lane_reset_i  input  NUM_LANES  per-lane release pulse from the event router.
REQ-013 SHALL have port monitor_o  output  ariane_pkg::runtime_monitor_ctrl  allocation command to the event router.
REQ-014 SHALL have ports alloc_cnt_o and stall_cnt_o  output  32 each  statistics counters.

Function
REQ-015 SHALL keep a busy bitmap busy_q[NUM_LANES-1:0] and free count free_cnt_q = NUM_LANES minus popcount(busy_q).
REQ-016 SHALL have states RUN and FLUSH; reset enters RUN.
REQ-017 SHALL drive req_ready_o = (state==RUN) && (free_cnt_q >= need), need = 2 if effective two-lane else 1; req_ready_o SHALL NOT depend on req_valid_i.
REQ-018 SHALL treat a two-lane request as single-lane when tail_valid_q==0 (no parent entry).
REQ-019 SHALL assign lane0 = lowest-index free lane, lane1 = next-lowest free lane (two-lane only, else lane1=0).
REQ-020 SHALL, on acceptance in cycle t, set the allocated lanes busy from t+1 and drive monitor_o in t+1 for exactly one cycle: monitor_ins=1, idx, itype, lane0, lane1, two_lane, p_idx = tail_idx_q sampled at t.
REQ-021 SHALL drive monitor_o = '0 in every cycle without a registered allocation.
REQ-022 SHALL update tail_idx_q = req_idx_i and tail_valid_q = 1 on each acceptance.
REQ-023 SHALL clear busy_q[k] in t+1 when lane_reset_i[k]=1 in t; a released lane SHALL NOT be allocatable in the same cycle t.
REQ-024 SHALL, if release and allocation target the same lane in one cycle (protocol error), give allocation priority (lane stays busy).
REQ-025 SHALL clear tail_valid_q when busy_q becomes all-zero via releases with no same-cycle acceptance.
REQ-026 SHALL, on flush_i in RUN, suppress any acceptance that cycle, clear busy_q, tail_valid_q and the pending monitor_o, and go to FLUSH.
REQ-027 SHALL hold req_ready_o=0 for one cycle in FLUSH, then return to RUN; flush_i in FLUSH SHALL remain in FLUSH.
REQ-028 SHALL have combinational lane selection and registered monitor_o only; no other latency.

Reset
REQ-029 SHALL on rst_i set busy_q='0, tail_idx_q='0, tail_valid_q=0, state=RUN, monitor_o='0, counters=0; req_ready_o=1 in the first cycle after reset.
REQ-030 SHALL give rst_i priority over flush_i and all requests.

Configuration
REQ-031 SHALL implement statistics only when macro RM_ALLOC_STATS_EN is defined: alloc_cnt_o increments per acceptance, stall_cnt_o per cycle with req_valid_i && !req_ready_o in RUN, both wrap at 2^32.
REQ-032 SHALL, without RM_ALLOC_STATS_EN, tie alloc_cnt_o and stall_cnt_o to 0 and instantiate no counter flops.

Verification
REQ-033 SHALL cover: reset, then single request idx=2 -> next cycle monitor_o{ins=1,idx=2,lane0=0,two_lane=0}, busy=00001.
REQ-034 SHALL cover: idx=2 accepted, then two-lane idx=3 -> lane0=1, lane1=2, p_idx=2, two_lane=1, busy=00111.
REQ-035 SHALL cover: five single requests fill lanes 0..4 -> req_ready_o=0; lane_reset_i=00100 -> ready next cycle, next grant lane0=2.
REQ-036 SHALL cover: free_cnt=1 with two-lane request -> req_ready_o=0 until a second lane released.
REQ-037 SHALL cover: flush_i with valid request and busy=01011 -> no monitor_o pulse, busy=00000, ready=0 one cycle, then 1.
REQ-038 SHALL cover: with RM_ALLOC_STATS_EN, 3 grants and 4 stalled cycles -> alloc_cnt_o=3, stall_cnt_o=4; without it both read 0.
